// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue/capture stage.
package div_pkg;

  localparam int DIV_W = 10;

  // Quotient reported for a bypassed zero divisor; callers slice to their width.
  localparam logic [31:0] SAT_ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO holding {a,b} pairs; wrap-bit pointers distinguish
// full from empty, flush clears both pointers in one cycle.
module div_op_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_a,
  input  logic [W-1:0] push_b,
  input  logic         pop,
  output logic [W-1:0] head_a,
  output logic [W-1:0] head_b,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [2*W-1:0] mem_q [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign {head_a, head_b} = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {push_a, push_b};
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Operand issue / result capture stage in front of the fixed-point divider.
// Optional DIV_ISSUE_DVZ_BYPASS_EN: zero divisors are answered locally without a divider run.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int W     = DIV_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  output logic         div_start,
  output logic         div_sclr,
  input  logic         div_busy,
  input  logic         div_valid,
  input  logic [W-1:0] div_q,
  input  logic         div_dvz,
  input  logic         div_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic         out_dvz,
  output logic         out_ovf,
  output logic [15:0]  done_cnt
);

  div_state_e   state_q, state_d;
  logic [W-1:0] div_a_q, div_a_d;
  logic [W-1:0] div_b_q, div_b_d;
  logic         seen_busy_q, seen_busy_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_q_q, out_q_d;
  logic         out_dvz_q, out_dvz_d;
  logic         out_ovf_q, out_ovf_d;
  logic [15:0]  done_cnt_q, done_cnt_d;

  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [W-1:0] head_a;
  logic [W-1:0] head_b;

  div_op_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .push   (in_valid),
    .push_a (in_a),
    .push_b (in_b),
    .pop    (fifo_pop),
    .head_a (head_a),
    .head_b (head_b),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign div_start = (state_q == ST_ISSUE);
  assign div_sclr  = flush;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_dvz   = out_dvz_q;
  assign out_ovf   = out_ovf_q;
  assign done_cnt  = done_cnt_q;

  always_comb begin
    state_d     = state_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    seen_busy_d = seen_busy_q;
    out_valid_d = out_valid_q;
    out_q_d     = out_q_q;
    out_dvz_d   = out_dvz_q;
    out_ovf_d   = out_ovf_q;
    done_cnt_d  = done_cnt_q;
    fifo_pop    = 1'b0;

    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      seen_busy_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
`ifdef DIV_ISSUE_DVZ_BYPASS_EN
            if (head_b == '0) begin
              fifo_pop    = 1'b1;
              out_q_d     = SAT_ALL_ONES[W-1:0];
              out_dvz_d   = 1'b1;
              out_ovf_d   = 1'b0;
              out_valid_d = 1'b1;
              state_d     = ST_DRAIN;
            end else
`endif
            if (!div_busy) begin
              fifo_pop = 1'b1;
              div_a_d  = head_a;
              div_b_d  = head_b;
              state_d  = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          seen_busy_d = 1'b0;
          state_d     = ST_WAIT;
        end
        ST_WAIT: begin
          if (div_busy) seen_busy_d = 1'b1;
          // A valid seen before busy has risen belongs to the previous operation.
          if (seen_busy_q && div_valid && !div_busy) begin
            out_q_d     = div_q;
            out_dvz_d   = div_dvz;
            out_ovf_d   = div_ovf;
            out_valid_d = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            done_cnt_d  = done_cnt_q + 16'd1;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      div_a_q     <= '0;
      div_b_q     <= '0;
      seen_busy_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_dvz_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      seen_busy_q <= seen_busy_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      out_dvz_q   <= out_dvz_d;
      out_ovf_q   <= out_ovf_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

endmodule
